// File: rtl/systolic_feed_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : systolic_feed_buffer                                       |
// | Description : Double-tile staging buffer that drains A/B tiles as skewed |
// |               row/column feeds into a SIZE x SIZE systolic array.        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module systolic_feed_buffer #(
  parameter int SIZE = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [255:0]      buf_data_in,
  input  logic              wr_valid,
  input  logic              read_a,
  input  logic              read_b,
  output logic              wr_ready,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [8*SIZE-1:0] a_feed,
  output logic [8*SIZE-1:0] b_feed,
  output logic              feed_valid,
  output logic              feed_last,
  input  logic              clear,
  output logic              err_overflow
);

  localparam int c_DW = 8 * SIZE;
  localparam int c_RW = $clog2(SIZE);
  localparam int c_TW = $clog2(2 * SIZE - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(SIZE - 1);
  localparam logic [c_TW-1:0] c_T_LAST   = c_TW'(2 * SIZE - 2);

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_FULL  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_RW-1:0] r_row_a;
  logic [c_RW-1:0] r_row_b;
  logic            r_a_full;
  logic            r_b_full;
  logic [c_TW-1:0] r_t;
  logic [c_TW-1:0] w_t_next;
  logic            r_err;
  logic            r_feed_valid;
  logic            r_feed_last;
  logic [c_DW-1:0] r_a_feed;
  logic [c_DW-1:0] r_b_feed;
  logic [c_DW-1:0] w_a_next;
  logic [c_DW-1:0] w_b_next;
  logic [c_DW-1:0] r_tile_a [SIZE];
  logic [c_DW-1:0] r_tile_b [SIZE];
  logic            w_fill;
  logic            w_wr_a;
  logic            w_wr_b;
  logic            w_drop;
  logic            w_drain_done;
  logic            w_unused_data;

  // Bytes above the configured tile width are intentionally ignored.
  assign w_unused_data = ^buf_data_in;

  assign w_fill       = (r_state == c_ST_FILL) && wr_valid && !clear;
  assign w_wr_a       = w_fill && read_a && !read_b && !r_a_full;
  assign w_wr_b       = w_fill && read_b && !read_a && !r_b_full;
  assign w_drop       = wr_valid && !w_wr_a && !w_wr_b;
  assign w_drain_done = (r_state == c_ST_DRAIN) && (r_t == c_T_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_ST_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = c_ST_FILL;
    end else begin
      case (r_state)
        c_ST_FILL:  if (r_a_full && r_b_full) w_state_next = c_ST_FULL;
        c_ST_FULL:  if (tile_ready)           w_state_next = c_ST_DRAIN;
        c_ST_DRAIN: if (r_t == c_T_LAST)      w_state_next = c_ST_FILL;
        default:                              w_state_next = c_ST_FILL;
      endcase
    end
  end

  always_comb begin
    wr_ready   = (r_state == c_ST_FILL);
    tile_valid = (r_state == c_ST_FULL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row_a  <= '0;
      r_row_b  <= '0;
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
    end else if (clear || w_drain_done) begin
      r_row_a  <= '0;
      r_row_b  <= '0;
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
    end else begin
      if (w_wr_a) begin
        r_row_a <= (r_row_a == c_ROW_LAST) ? '0 : r_row_a + c_RW'(1);
        if (r_row_a == c_ROW_LAST) r_a_full <= 1'b1;
      end
      if (w_wr_b) begin
        r_row_b <= (r_row_b == c_ROW_LAST) ? '0 : r_row_b + c_RW'(1);
        if (r_row_b == c_ROW_LAST) r_b_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_err <= 1'b0;
    else if (clear)  r_err <= 1'b0;
    else if (w_drop) r_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_a) r_tile_a[r_row_a] <= buf_data_in[c_DW-1:0];
    if (w_wr_b) r_tile_b[r_row_b] <= buf_data_in[c_DW-1:0];
  end

  // Feed for the index the next cycle will present, so outputs can be registered.
  assign w_t_next = (r_state == c_ST_DRAIN) ? r_t + c_TW'(1) : '0;

  always_comb begin
    w_a_next = '0;
    w_b_next = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (int'(w_t_next) == i + k) begin
          w_a_next[8*i +: 8] = r_tile_a[i][8*k +: 8];
          w_b_next[8*i +: 8] = r_tile_b[k][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_t          <= '0;
      r_feed_valid <= 1'b0;
      r_feed_last  <= 1'b0;
      r_a_feed     <= '0;
      r_b_feed     <= '0;
    end else if (w_state_next == c_ST_DRAIN) begin
      r_t          <= w_t_next;
      r_feed_valid <= 1'b1;
      r_feed_last  <= (w_t_next == c_T_LAST);
      r_a_feed     <= w_a_next;
      r_b_feed     <= w_b_next;
    end else begin
      r_t          <= '0;
      r_feed_valid <= 1'b0;
      r_feed_last  <= 1'b0;
      r_a_feed     <= '0;
      r_b_feed     <= '0;
    end
  end

  assign a_feed       = r_a_feed;
  assign b_feed       = r_b_feed;
  assign feed_valid   = r_feed_valid;
  assign feed_last    = r_feed_last;
  assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_systolic_feed_buffer                                    |
// | Description : Directed/randomized bench with a tile-level model.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_systolic_feed_buffer;

  localparam int SIZE   = 4;
  localparam int T_LAST = 2 * SIZE - 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [255:0]      buf_data_in = '0;
  logic              wr_valid = 1'b0;
  logic              read_a = 1'b0;
  logic              read_b = 1'b0;
  logic              tile_ready = 1'b0;
  logic              clear = 1'b0;
  logic              wr_ready;
  logic              tile_valid;
  logic              feed_valid;
  logic              feed_last;
  logic              err_overflow;
  logic [8*SIZE-1:0] a_feed;
  logic [8*SIZE-1:0] b_feed;

  int   checks = 0;
  int   errors = 0;

  // Reference model: tile contents, rows accepted per side, expected sticky flag.
  logic [7:0] ma [SIZE][SIZE];
  logic [7:0] mb [SIZE][SIZE];
  int         na = 0;
  int         nb = 0;
  logic       filling = 1'b1;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  systolic_feed_buffer #(.SIZE(SIZE)) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .buf_data_in  (buf_data_in),
    .wr_valid     (wr_valid),
    .read_a       (read_a),
    .read_b       (read_b),
    .wr_ready     (wr_ready),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .a_feed       (a_feed),
    .b_feed       (b_feed),
    .feed_valid   (feed_valid),
    .feed_last    (feed_last),
    .clear        (clear),
    .err_overflow (err_overflow)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*SIZE-1:0] exp_a(input int t);
    logic [8*SIZE-1:0] v = '0;
    for (int i = 0; i < SIZE; i++)
      if (t - i >= 0 && t - i < SIZE) v[8*i +: 8] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [8*SIZE-1:0] exp_b(input int t);
    logic [8*SIZE-1:0] v = '0;
    for (int j = 0; j < SIZE; j++)
      if (t - j >= 0 && t - j < SIZE) v[8*j +: 8] = mb[t-j][j];
    return v;
  endfunction

  task automatic beat(input logic ra, input logic rb, input logic [8*SIZE-1:0] row);
    for (int w = 0; w < 8; w++) buf_data_in[32*w +: 32] = $urandom();
    buf_data_in[8*SIZE-1:0] = row;
    wr_valid = 1'b1;
    read_a   = ra;
    read_b   = rb;
    if (filling && (ra != rb) && (ra ? (na < SIZE) : (nb < SIZE))) begin
      for (int k = 0; k < SIZE; k++) begin
        if (ra) ma[na][k] = row[8*k +: 8];
        else    mb[nb][k] = row[8*k +: 8];
      end
      if (ra) na++;
      else    nb++;
    end else begin
      exp_err = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
    read_a   = 1'b0;
    read_b   = 1'b0;
    chk("err_overflow_after_beat", err_overflow, exp_err);
  endtask

  function automatic logic [8*SIZE-1:0] mk_row(input bit pattern, input bit is_a, input int r);
    logic [8*SIZE-1:0] v;
    for (int k = 0; k < SIZE; k++)
      v[8*k +: 8] = pattern ? (is_a ? 8'(16*r + k) : 8'(128 + 4*r + k)) : 8'($urandom());
    return v;
  endfunction

  task automatic fill_side(input bit is_a, input bit pattern);
    for (int r = 0; r < SIZE; r++) beat(is_a, !is_a, mk_row(pattern, is_a, r));
  endtask

  task automatic wait_full();
    chk("tile_valid_before_full", tile_valid, 1'b0);
    tick();
    chk("tile_valid_full", tile_valid, 1'b1);
    chk("wr_ready_full", wr_ready, 1'b0);
    filling = 1'b0;
  endtask

  task automatic drain(input int stop_at, input bit pattern);
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    for (int t = 0; t <= T_LAST; t++) begin
      chk("feed_valid", feed_valid, 1'b1);
      chk("feed_last", feed_last, logic'(t == T_LAST));
      chk("a_feed", a_feed, exp_a(t));
      chk("b_feed", b_feed, exp_b(t));
      if (pattern && t == 0) begin
        chk("a_feed_t0_const", a_feed, 32'h0000_0000);
        chk("b_feed_t0_const", b_feed, 32'h0000_0080);
      end
      if (pattern && t == 3) begin
        chk("a_feed_t3_const", a_feed, 32'h3021_1203);
        chk("b_feed_t3_const", b_feed, 32'h8386_898C);
      end
      if (t == stop_at) return;
      tick();
    end
    chk("feed_valid_after_drain", feed_valid, 1'b0);
    chk("wr_ready_after_drain", wr_ready, 1'b1);
    chk("tile_valid_after_drain", tile_valid, 1'b0);
    filling = 1'b1;
    na = 0;
    nb = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_err = 1'b0;
    filling = 1'b1;
    na = 0;
    nb = 0;
    chk("err_after_clear", err_overflow, 1'b0);
    chk("wr_ready_after_clear", wr_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_tile_valid", tile_valid, 1'b0);
    chk("rst_feed_valid", feed_valid, 1'b0);
    chk("rst_feed_last", feed_last, 1'b0);
    chk("rst_a_feed", a_feed, '0);
    chk("rst_b_feed", b_feed, '0);
    chk("rst_err", err_overflow, 1'b0);
    #10;
    rstn = 1'b1;
    tick();

    // Known-pattern fill then drain
    fill_side(1'b1, 1'b1);
    fill_side(1'b0, 1'b1);
    wait_full();
    drain(-1, 1'b1);

    // Interleaved B/A beats with random data
    for (int r = 0; r < SIZE; r++) begin
      beat(1'b0, 1'b1, mk_row(1'b0, 1'b0, r));
      beat(1'b1, 1'b0, mk_row(1'b0, 1'b1, r));
    end
    wait_full();
    chk("err_interleaved", err_overflow, 1'b0);
    drain(-1, 1'b0);

    // Back-pressure in FULL, then a stray beat
    fill_side(1'b1, 1'b0);
    fill_side(1'b0, 1'b0);
    wait_full();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_tile_valid", tile_valid, 1'b1);
      chk("bp_wr_ready", wr_ready, 1'b0);
      chk("bp_feed_valid", feed_valid, 1'b0);
    end
    beat(1'b1, 1'b0, mk_row(1'b0, 1'b1, 0));
    drain(-1, 1'b0);
    chk("err_sticky_after_drain", err_overflow, 1'b1);
    do_clear();

    // Overflow on a full side plus malformed selects
    fill_side(1'b1, 1'b0);
    beat(1'b1, 1'b0, mk_row(1'b0, 1'b1, 0));
    beat(1'b0, 1'b0, mk_row(1'b0, 1'b1, 0));
    beat(1'b1, 1'b1, mk_row(1'b0, 1'b1, 0));
    fill_side(1'b0, 1'b0);
    wait_full();
    drain(-1, 1'b0);
    chk("err_sticky_overflow", err_overflow, 1'b1);
    do_clear();

    // Reset in the middle of a drain
    fill_side(1'b1, 1'b0);
    fill_side(1'b0, 1'b0);
    wait_full();
    drain(2, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rst_mid_feed_valid", feed_valid, 1'b0);
    chk("rst_mid_feed_last", feed_last, 1'b0);
    chk("rst_mid_a_feed", a_feed, '0);
    chk("rst_mid_wr_ready", wr_ready, 1'b1);
    chk("rst_mid_tile_valid", tile_valid, 1'b0);
    #2;
    rstn = 1'b1;
    filling = 1'b1;
    na = 0;
    nb = 0;
    exp_err = 1'b0;
    tick();
    chk("post_rst_wr_ready", wr_ready, 1'b1);
    chk("post_rst_feed_valid", feed_valid, 1'b0);

    // Clear coinciding with the final A beat
    for (int r = 0; r < SIZE - 1; r++) beat(1'b1, 1'b0, mk_row(1'b0, 1'b1, r));
    buf_data_in = '1;
    wr_valid = 1'b1;
    read_a = 1'b1;
    clear = 1'b1;
    tick();
    wr_valid = 1'b0;
    read_a = 1'b0;
    clear = 1'b0;
    filling = 1'b1;
    na = 0;
    nb = 0;
    exp_err = 1'b0;
    chk("clr_beat_wr_ready", wr_ready, 1'b1);
    chk("clr_beat_tile_valid", tile_valid, 1'b0);
    chk("clr_beat_err", err_overflow, 1'b0);
    fill_side(1'b1, 1'b0);
    fill_side(1'b0, 1'b0);
    wait_full();
    drain(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
